// File: rtl/lcd_watch_hour_set.sv
// 12-hour AM/PM hour editor for an LCD watch: tracks the running hour while idle,
// lets the user adjust it in edit mode, and strobes the committed 24-hour value out.
module lcd_watch_hour_set #(
   parameter logic [15:0] TIMEOUT = 16'd1000
) (
   input  logic       CLK,
   input  logic       RESETN,
   input  logic [6:0] CUR_HOUR,
   input  logic       SET_EN,
   input  logic       BTN_UP,
   input  logic       BTN_DOWN,
   input  logic       BTN_AMPM,
   input  logic       BTN_OK,
   output logic [3:0] HOUR_AMPM10,
   output logic [3:0] HOUR_AMPM1,
   output logic       PM,
   output logic       SET_MODE,
   output logic       HOUR_LOAD,
   output logic [6:0] HOUR_OUT
);

   typedef enum logic [1:0] {IDLE, EDIT, LOAD} state_t;

   localparam logic [15:0] TMO_LAST = TIMEOUT - 16'd1;

   state_t      state_reg, state_next;
   logic [3:0]  cnt_reg, cnt_next;
   logic        pm_reg, pm_next;
   logic [15:0] tmo_reg, tmo_next;
   logic [6:0]  hour_out_reg, hour_out_next;
   logic [3:0]  ampm10_reg, ampm1_reg;
   logic        pm_out_reg, set_mode_reg, hour_load_reg;

   logic [3:0]  cur_cnt;
   logic        cur_pm;
   logic [3:0]  src_cnt;
   logic        src_pm;
   logic [3:0]  disp_tens, disp_units;

   // Out-of-range hours fold to midnight so the editor never starts from garbage.
   always_comb begin
      cur_cnt = 4'd0;
      cur_pm  = 1'b0;
      if (CUR_HOUR <= 7'd11) begin
         cur_cnt = CUR_HOUR[3:0];
      end else if (CUR_HOUR <= 7'd23) begin
         cur_cnt = 4'(CUR_HOUR - 7'd12);
         cur_pm  = 1'b1;
      end
   end

   always_comb begin
      src_cnt    = (state_reg == IDLE) ? cur_cnt : cnt_reg;
      src_pm     = (state_reg == IDLE) ? cur_pm  : pm_reg;
      disp_tens  = 4'd0;
      disp_units = src_cnt;
      if (src_cnt == 4'd0) begin
         disp_tens  = src_pm ? 4'd1 : 4'd0;
         disp_units = src_pm ? 4'd2 : 4'd0;
      end else if (src_cnt >= 4'd10) begin
         disp_tens  = 4'd1;
         disp_units = src_cnt - 4'd10;
      end
   end

   // One action per edit cycle; the if/else chain encodes the button priority.
   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      pm_next       = pm_reg;
      tmo_next      = tmo_reg;
      hour_out_next = hour_out_reg;
      case (state_reg)
         IDLE: begin
            if (SET_EN) begin
               cnt_next   = cur_cnt;
               pm_next    = cur_pm;
               tmo_next   = 16'd0;
               state_next = EDIT;
            end
         end
         EDIT: begin
            tmo_next = 16'd0;
            if (SET_EN) begin
               state_next = IDLE;
            end else if (BTN_OK) begin
               hour_out_next = {3'd0, cnt_reg} + (pm_reg ? 7'd12 : 7'd0);
               state_next    = LOAD;
            end else if (BTN_AMPM) begin
               pm_next = ~pm_reg;
            end else if (BTN_UP) begin
               cnt_next = (cnt_reg >= 4'd11) ? 4'd0 : cnt_reg + 4'd1;
            end else if (BTN_DOWN) begin
               cnt_next = (cnt_reg == 4'd0) ? 4'd11 : cnt_reg - 4'd1;
            end else if (tmo_reg >= TMO_LAST) begin
               state_next = IDLE;
            end else begin
               tmo_next = tmo_reg + 16'd1;
            end
         end
         LOAD:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_reg     <= IDLE;
         cnt_reg       <= 4'd0;
         pm_reg        <= 1'b0;
         tmo_reg       <= 16'd0;
         hour_out_reg  <= 7'd0;
         ampm10_reg    <= 4'd0;
         ampm1_reg     <= 4'd0;
         pm_out_reg    <= 1'b0;
         set_mode_reg  <= 1'b0;
         hour_load_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         pm_reg        <= pm_next;
         tmo_reg       <= tmo_next;
         hour_out_reg  <= hour_out_next;
         ampm10_reg    <= disp_tens;
         ampm1_reg     <= disp_units;
         pm_out_reg    <= src_pm;
         set_mode_reg  <= (state_next == EDIT);
         hour_load_reg <= (state_next == LOAD);
      end
   end

   assign HOUR_AMPM10 = ampm10_reg;
   assign HOUR_AMPM1  = ampm1_reg;
   assign PM          = pm_out_reg;
   assign SET_MODE    = set_mode_reg;
   assign HOUR_LOAD   = hour_load_reg;
   assign HOUR_OUT    = hour_out_reg;

endmodule

// File: tb/tb_lcd_watch_hour_set.sv
// Directed bench for lcd_watch_hour_set; committed hours go through a scoreboard
// queue that a HOUR_LOAD monitor drains.
module tb_lcd_watch_hour_set;

   logic       CLK, RESETN;
   logic [6:0] CUR_HOUR;
   logic       SET_EN, BTN_UP, BTN_DOWN, BTN_AMPM, BTN_OK;
   logic [3:0] HOUR_AMPM10, HOUR_AMPM1;
   logic       PM, SET_MODE, HOUR_LOAD;
   logic [6:0] HOUR_OUT;

   int n_checks = 0;
   int n_pass   = 0;
   int exp_q[$];

   lcd_watch_hour_set #(.TIMEOUT(16'd8)) dut (
      .CLK(CLK), .RESETN(RESETN), .CUR_HOUR(CUR_HOUR),
      .SET_EN(SET_EN), .BTN_UP(BTN_UP), .BTN_DOWN(BTN_DOWN),
      .BTN_AMPM(BTN_AMPM), .BTN_OK(BTN_OK),
      .HOUR_AMPM10(HOUR_AMPM10), .HOUR_AMPM1(HOUR_AMPM1), .PM(PM),
      .SET_MODE(SET_MODE), .HOUR_LOAD(HOUR_LOAD), .HOUR_OUT(HOUR_OUT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic chk_disp(input string tag, input int t, input int u, input int p);
      chk({tag, "_tens"}, 32'(HOUR_AMPM10), 32'(t));
      chk({tag, "_units"}, 32'(HOUR_AMPM1), 32'(u));
      chk({tag, "_pm"}, 32'(PM), 32'(p));
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic press(input logic s, input logic ok, input logic ap, input logic up, input logic dn);
      SET_EN = s; BTN_OK = ok; BTN_AMPM = ap; BTN_UP = up; BTN_DOWN = dn;
      tick();
      SET_EN = 0; BTN_OK = 0; BTN_AMPM = 0; BTN_UP = 0; BTN_DOWN = 0;
   endtask

   task automatic edit_cycles(input string tag);
      int n = 0;
      while (SET_MODE === 1'b1 && n < 50) begin
         tick();
         n++;
      end
      chk(tag, 32'(n), 32'd8);
   endtask

   // Each HOUR_LOAD strobe must match the oldest expected commit.
   always @(negedge CLK) begin
      if (HOUR_LOAD === 1'b1) begin
         n_checks++;
         assert (exp_q.size() != 0) n_pass++;
         else $error("FAIL unexpected_load: observed HOUR_OUT %0d expected no strobe", HOUR_OUT);
         if (exp_q.size() != 0) chk("hour_out_at_load", 32'(HOUR_OUT), 32'(exp_q.pop_front()));
      end
   end

   initial begin
      RESETN = 1; CUR_HOUR = 0;
      SET_EN = 0; BTN_OK = 0; BTN_AMPM = 0; BTN_UP = 0; BTN_DOWN = 0;
      #2 RESETN = 0;
      #2;
      chk_disp("reset", 0, 0, 0);
      chk("reset_set_mode", 32'(SET_MODE), 0);
      chk("reset_load", 32'(HOUR_LOAD), 0);
      chk("reset_hour_out", 32'(HOUR_OUT), 0);
      repeat (2) tick();
      RESETN = 1;

      // 15 -> 03 PM, commit 15; CUR_HOUR changes in EDIT are ignored
      CUR_HOUR = 15;
      tick();
      chk_disp("idle_15", 0, 3, 1);
      press(1, 0, 0, 0, 0);
      chk("edit_set_mode", 32'(SET_MODE), 1);
      chk_disp("edit_15", 0, 3, 1);
      CUR_HOUR = 4;
      tick();
      chk_disp("edit_cur_change", 0, 3, 1);
      exp_q.push_back(15);
      press(0, 1, 0, 0, 0);
      chk("load_strobe", 32'(HOUR_LOAD), 1);
      chk("load_hour_out", 32'(HOUR_OUT), 15);
      tick();
      chk("load_one_cycle", 32'(HOUR_LOAD), 0);
      chk("after_load_mode", 32'(SET_MODE), 0);
      tick();
      chk_disp("idle_4", 0, 4, 0);
      chk("hold_hour_out", 32'(HOUR_OUT), 15);

      CUR_HOUR = 30;
      tick();
      chk_disp("idle_out_of_range", 0, 0, 0);

      // IDLE ignores non-SET buttons
      press(0, 1, 1, 1, 1);
      chk("idle_ignore_mode", 32'(SET_MODE), 0);
      tick();

      // 11 AM, UP wraps to 00 AM, AMPM -> 12 PM, commit 12
      CUR_HOUR = 11;
      tick();
      press(1, 0, 0, 0, 0);
      press(0, 0, 0, 1, 0);
      tick();
      chk_disp("wrap_up", 0, 0, 0);
      press(0, 0, 1, 0, 0);
      tick();
      chk_disp("ampm_noon", 1, 2, 1);
      exp_q.push_back(12);
      press(0, 1, 0, 0, 0);
      repeat (2) tick();

      // 0 AM, DOWN wraps to 11 AM, commit 11
      CUR_HOUR = 0;
      tick();
      press(1, 0, 0, 0, 0);
      press(0, 0, 0, 0, 1);
      tick();
      chk_disp("wrap_down", 1, 1, 0);
      exp_q.push_back(11);
      press(0, 1, 0, 0, 0);
      repeat (2) tick();

      // cancel beats OK in the same cycle
      CUR_HOUR = 9;
      tick();
      press(1, 0, 0, 0, 0);
      press(1, 1, 0, 0, 0);
      chk("cancel_mode", 32'(SET_MODE), 0);
      chk("cancel_no_load", 32'(HOUR_LOAD), 0);
      tick();
      chk("cancel_hour_out", 32'(HOUR_OUT), 11);

      // AMPM beats UP, UP beats DOWN
      CUR_HOUR = 5;
      tick();
      press(1, 0, 0, 0, 0);
      press(0, 0, 1, 1, 0);
      tick();
      chk_disp("prio_ampm", 0, 5, 1);
      press(0, 0, 0, 1, 1);
      tick();
      chk_disp("prio_up", 0, 6, 1);
      exp_q.push_back(18);
      press(0, 1, 0, 0, 0);
      repeat (2) tick();

      // timeout after 8 idle EDIT cycles; a button restarts the count
      CUR_HOUR = 2;
      tick();
      press(1, 0, 0, 0, 0);
      edit_cycles("timeout_cycles");
      press(1, 0, 0, 0, 0);
      repeat (5) tick();
      press(0, 0, 0, 1, 0);
      edit_cycles("timeout_restart");
      chk("timeout_hour_out", 32'(HOUR_OUT), 18);

      // async reset in EDIT at 07 PM
      CUR_HOUR = 19;
      tick();
      press(1, 0, 0, 0, 0);
      tick();
      chk_disp("pre_reset", 0, 7, 1);
      #2 RESETN = 0;
      #1;
      chk_disp("async_reset", 0, 0, 0);
      chk("async_reset_mode", 32'(SET_MODE), 0);
      chk("async_reset_hour_out", 32'(HOUR_OUT), 0);
      CUR_HOUR = 20;
      #3 RESETN = 1;
      tick();
      chk_disp("post_reset_20", 0, 8, 1);
      chk("post_reset_mode", 32'(SET_MODE), 0);
      repeat (2) tick();

      chk("scoreboard_drained", 32'(exp_q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
